// File: rtl/demux1_2_buf.sv
// 1:2 valid/ready demultiplexer with an independent FIFO per output.
// Optional per-output push counters are enabled with the DEMUX_STAT_EN macro.
module demux1_2_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [31:0]       cnt0,
    output logic [31:0]       cnt1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     wr_ptr_d [2];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [AW-1:0]     rd_ptr_d [2];
    logic [AW:0]       occ_q    [2];
    logic [AW:0]       occ_d    [2];
    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [DATA_W-1:0] mem_d    [2][DEPTH];

    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready_v;

    // Handshake decode; a full FIFO never accepts, even with a same-cycle pop.
    always_comb begin
        out_ready_v = {out1_ready, out0_ready};
        for (int i = 0; i < 2; i++) begin
            full[i]      = (occ_q[i] == FULL_OCC);
            not_empty[i] = (occ_q[i] != '0);
        end
        in_ready = ~full[in_sel] & ~flush & ~rst;
        push     = '0;
        if (in_valid && in_ready) begin
            push[in_sel] = 1'b1;
        end
        pop = not_empty & out_ready_v & {2{~flush & ~rst}};
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            occ_d[i]    = occ_q[i];
            mem_d[i]    = mem_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            end
            occ_d[i] = occ_q[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                occ_d[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end else begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                occ_q[i]    <= occ_d[i];
            end
        end
    end

    // Payload storage carries no reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign out0_valid = not_empty[0];
    assign out1_valid = not_empty[1];
    assign out0_data  = mem_q[0][rd_ptr_q[0]];
    assign out1_data  = mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX_STAT_EN
    logic [31:0] stat_q [2];
    logic [31:0] stat_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stat_d[i] = stat_q[i] + 32'(push[i]);
        end
    end

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    assign cnt0 = stat_q[0];
    assign cnt1 = stat_q[1];
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_demux1_2_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
`ifdef DEMUX_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sel = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out0_valid;
    logic              out0_ready = 1'b0;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready = 1'b0;
    logic [DATA_W-1:0] out1_data;
    logic [31:0]       cnt0;
    logic [31:0]       cnt1;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [31:0]       m_cnt0 = 0;
    logic [31:0]       m_cnt1 = 0;

    demux1_2_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: apply the spec's rules to the current inputs, then clock.
    task automatic tick();
        bit acc, p0, p1;
        acc = 1'b0; p0 = 1'b0; p1 = 1'b0;
        if (!rst && !flush) begin
            acc = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
            p0  = out0_ready && (q0.size() > 0);
            p1  = out1_ready && (q1.size() > 0);
        end
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); m_cnt0 = 0; m_cnt1 = 0;
        end else if (flush) begin
            q0.delete(); q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc && !in_sel) begin q0.push_back(in_data); m_cnt0 = m_cnt0 + 1; end
            if (acc && in_sel)  begin q1.push_back(in_data); m_cnt1 = m_cnt1 + 1; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        tick();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b%b exp 00", out0_valid, out1_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready2: got %b exp 0", in_ready); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_after: got v=%b%b cnt0=%0d cnt1=%0d exp v=00 cnt=0",
                     out0_valid, out1_valid, cnt0, cnt1);
        end
    endtask

    task automatic test_routing();
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5_0001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready0: got %b exp 1", in_ready); end
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL route_no_comb_path: got %b exp 0", out0_valid); end
        tick();
        in_sel = 1'b1; in_data = 32'h5A5A_0002;
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hA5A5_0001 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL route_out0: got v=%b d=%h v1=%b exp v=1 d=a5a50001 v1=0",
                               out0_valid, out0_data, out1_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h5A5A_0002 || out0_valid !== 1'b0) begin
            errors++; $display("FAIL route_out1: got v=%b d=%h v0=%b exp v=1 d=5a5a0002 v0=0",
                               out1_valid, out1_data, out0_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd1;
        tick();
        in_data = 32'd2;
        tick();
        in_data = 32'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b exp 0", in_ready); end
        tick();
        in_sel = 1'b1; in_data = 32'h33;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        #1;
        checks++;
        if (out0_data !== 32'd1 || out1_data !== 32'h33 || !out0_valid || !out1_valid) begin
            errors++; $display("FAIL bp_head1: got d0=%h d1=%h exp d0=1 d1=33", out0_data, out1_data);
        end
        tick();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'd2) begin
            errors++; $display("FAIL bp_head2: got v=%b d=%h exp v=1 d=2", out0_valid, out0_data);
        end
        tick();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got %b%b exp 00", out0_valid, out1_valid);
        end
    endtask

    task automatic test_full_pop();
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h41;
        tick();
        in_data = 32'h42;
        tick();
        out0_ready = 1'b1; in_data = 32'h43;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready: got %b exp 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out0_data !== 32'h42) begin
            errors++; $display("FAIL fullpop_next: got r=%b d=%h exp r=1 d=42", in_ready, out0_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h43) begin
            errors++; $display("FAIL fullpop_order: got v=%b d=%h exp v=1 d=43", out0_valid, out0_data);
        end
        tick();
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b exp 0", out0_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] c0, c1;
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h51;
        tick();
        in_data = 32'h52;
        tick();
        in_sel = 1'b1; in_data = 32'h61;
        tick();
        c0 = STAT ? m_cnt0 : 32'd0;
        c1 = STAT ? m_cnt1 : 32'd0;
        flush = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1; in_data = 32'h99;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got r=%b v=%b%b exp r=0 v=11", in_ready, out0_valid, out1_valid);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %b%b exp 00", out0_valid, out1_valid);
        end
        checks++;
        if (cnt0 !== c0 || cnt1 !== c1) begin
            errors++; $display("FAIL flush_cnt: got %0d/%0d exp %0d/%0d", cnt0, cnt1, c0, c1);
        end
    endtask

    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            tick();
        end
        in_sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom;
            tick();
        end
        in_data = 32'h7777;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stat_stall_ready: got %b exp 0", in_ready); end
        tick();
        in_valid = 1'b0; out1_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b1; in_data = 32'h8888;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (cnt0 !== (STAT ? 32'd5 : 32'd0) || cnt1 !== (STAT ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL stat_counts: got %0d/%0d exp %0d/%0d",
                               cnt0, cnt1, STAT ? 5 : 0, STAT ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_random();
        bit exp_r;
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            in_valid   = $urandom_range(0, 1);
            in_sel     = $urandom_range(0, 1);
            in_data    = $urandom;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            #1;
            exp_r = !rst && !flush && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
            checks++;
            if (in_ready !== exp_r) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b exp %b", n, in_ready, exp_r);
            end
            checks++;
            if (out0_valid !== (q0.size() > 0) || (q0.size() > 0 && out0_data !== q0[0])) begin
                errors++; $display("FAIL rand_out0[%0d]: got v=%b d=%h exp v=%b d=%h", n,
                                   out0_valid, out0_data, q0.size() > 0, q0.size() > 0 ? q0[0] : 32'h0);
            end
            checks++;
            if (out1_valid !== (q1.size() > 0) || (q1.size() > 0 && out1_data !== q1[0])) begin
                errors++; $display("FAIL rand_out1[%0d]: got v=%b d=%h exp v=%b d=%h", n,
                                   out1_valid, out1_data, q1.size() > 0, q1.size() > 0 ? q1[0] : 32'h0);
            end
            checks++;
            if (cnt0 !== (STAT ? m_cnt0 : 32'd0) || cnt1 !== (STAT ? m_cnt1 : 32'd0)) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d exp %0d/%0d", n, cnt0, cnt1,
                                   STAT ? m_cnt0 : 0, STAT ? m_cnt1 : 0);
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
